nibble_word_packer: RTL and testbench

//  Streaming packer: accepts 4-bit nibbles over a valid/ready handshake and assembles them into a
//  128-bit word whose lower NIBBLES*4 bits carry lanes L0..L(NIBBLES-1). Upper bits are zero.

---
 rtl/nibble_pack_pkg.sv | 52 +++++
 rtl/nibble_word_packer_if.sv | 36 +++
 rtl/nibble_pack_outreg.sv | 30 +++
 rtl/nibble_word_packer.sv | 108 ++++++++++
 tb/tb_nibble_word_packer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/nibble_pack_pkg.sv
// Shared types, widths and helpers for the nibble-to-word packer.
// Optional per-lane parity is enabled by defining NIBBLES_PACKER_PARITY_EN.
package nibble_pack_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned WORD_W      = 128;
    localparam int unsigned MAX_NIBBLES = 32;
    localparam int unsigned CNT_W       = 6;
    localparam int unsigned LANE_W      = 5;
    localparam int unsigned PAR_W       = 32;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [PAR_W-1:0]  par_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_e;

    // Payload carried by the one-entry output register
    typedef struct packed {
        word_t word;
        cnt_t  count;
`ifdef NIBBLES_PACKER_PARITY_EN
        par_t  par;
`endif
    } out_word_t;

    // Lane written by the cnt-th accepted nibble of a word
    function automatic logic [LANE_W-1:0] lane_idx(input cnt_t cnt, input logic order,
                                                   input int unsigned nibbles);
        cnt_t top_lane;
        top_lane = CNT_W'(nibbles - 1);
        if (order) begin
            return LANE_W'(top_lane - cnt);
        end
        return LANE_W'(cnt);
    endfunction

    // Even parity of every nibble lane; zero-filled lanes yield 0
    function automatic par_t lane_parity(input word_t word);
        par_t par;
        par = '0;
        for (int k = 0; k < int'(PAR_W); k++) begin
            par[k] = ^word[k*NIB_W +: NIB_W];
        end
        return par;
    endfunction

endpackage

// File: rtl/nibble_word_packer_if.sv
// Nibble input stream and packed-word output stream of the packer.
// out_par exists only when NIBBLES_PACKER_PARITY_EN is defined.
interface nibble_word_packer_if;
    import nibble_pack_pkg::*;

    logic  in_valid;
    logic  in_ready;
    nib_t  in_nib;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    word_t out;
    cnt_t  out_count;
`ifdef NIBBLES_PACKER_PARITY_EN
    par_t  out_par;
`endif

    // Source of nibbles and consumer of words
    modport master (
`ifdef NIBBLES_PACKER_PARITY_EN
        input  out_par,
`endif
        output in_valid, in_nib, in_last, out_ready,
        input  in_ready, out_valid, out, out_count
    );

    // Packer side
    modport slave (
`ifdef NIBBLES_PACKER_PARITY_EN
        output out_par,
`endif
        input  in_valid, in_nib, in_last, out_ready,
        output in_ready, out_valid, out, out_count
    );

endinterface

// File: rtl/nibble_pack_outreg.sv
// One-entry output register with valid/ready; accepts a load in the same cycle it is popped.
module nibble_pack_outreg
    import nibble_pack_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  out_word_t d,
    input  logic      out_ready,
    output logic      out_valid,
    output out_word_t q,
    output logic      slot_free_c
);

    assign slot_free_c = !out_valid || out_ready;

    // Payload only changes on load, so it is held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_word_packer.sv
// Streaming packer: assembles 4-bit nibbles into a 128-bit word of NIBBLES lanes.
// Define NIBBLES_PACKER_PARITY_EN to add registered per-lane even parity on out_par.
module nibble_word_packer
    import nibble_pack_pkg::*;
#(
    parameter int unsigned NIBBLES = 20,
    parameter int unsigned ORDER   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_word_packer_if.slave  bus
);

    if (NIBBLES < 1 || NIBBLES > MAX_NIBBLES || ORDER > 1) begin : g_param_err
        $error("nibble_word_packer: NIBBLES must be 1..32 and ORDER 0 or 1");
    end

    localparam cnt_t LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam logic ORDER_B  = (ORDER != 0);

    pack_state_e       state, state_nxt;
    word_t             acc, acc_nxt, word_ins;
    cnt_t              cnt, cnt_nxt;
    logic [LANE_W-1:0] idx;
    logic              accept, complete, slot_free_c, load;
    out_word_t         load_d, q;

    assign bus.in_ready = (state == FILL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign complete     = accept && ((cnt == LAST_CNT) || bus.in_last);

    // Accumulator with the incoming nibble dropped into its lane
    always_comb begin
        idx      = lane_idx(cnt, ORDER_B, NIBBLES);
        word_ins = acc;
        word_ins[{idx, 2'b00} +: NIB_W] = bus.in_nib;
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        load         = 1'b0;
        load_d       = '0;
        load_d.word  = word_ins;
        load_d.count = cnt + CNT_W'(1);
        case (state)
            FILL: begin
                if (complete && slot_free_c) begin
                    load    = 1'b1;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end else if (accept) begin
                    // A completed word that cannot leave parks here with its count
                    acc_nxt = word_ins;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (complete) begin
                        state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                load_d.word  = acc;
                load_d.count = cnt;
                if (slot_free_c) begin
                    load      = 1'b1;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
`ifdef NIBBLES_PACKER_PARITY_EN
        load_d.par = lane_parity(load_d.word);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    nibble_pack_outreg u_outreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .d           (load_d),
        .out_ready   (bus.out_ready),
        .out_valid   (bus.out_valid),
        .q           (q),
        .slot_free_c (slot_free_c)
    );

    assign bus.out       = q.word;
    assign bus.out_count = q.count;
`ifdef NIBBLES_PACKER_PARITY_EN
    assign bus.out_par   = q.par;
`endif

endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed bench for nibble_word_packer: ORDER=0 and ORDER=1 instances driven in lockstep.
module tb_nibble_word_packer;
    import nibble_pack_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stalls = 0;

    always #5 clk = ~clk;

    nibble_word_packer_if bus0 ();
    nibble_word_packer_if bus1 ();

    nibble_word_packer #(.NIBBLES(20), .ORDER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    nibble_word_packer #(.NIBBLES(20), .ORDER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    localparam logic [127:0] W1_O0 = 128'h3210FEDCBA9876543210;
    localparam logic [127:0] W1_O1 = 128'h0123456789ABCDEF0123;
    localparam logic [127:0] W2_O0 = 128'h76543210FEDCBA987654;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input nib_t n, input logic l);
        bus0.in_valid = v; bus0.in_nib = n; bus0.in_last = l;
        bus1.in_valid = v; bus1.in_nib = n; bus1.in_last = l;
    endtask

    task automatic set_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic push(input nib_t n, input logic l);
        int t;
        t = 0;
        drive(1'b1, n, l);
        while (!bus0.in_ready && t < 100) begin
            @(negedge clk);
            t++;
            stalls++;
        end
        if (t == 100) chk("push_timeout", 128'(bus0.in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 4'h0, 1'b0);
        set_ready(1'b1);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(bus0.out_valid), 128'd0);
        chk("rst_out", bus0.out, 128'd0);
        chk("rst_out_count", 128'(bus0.out_count), 128'd0);
        chk("rst_in_ready", 128'(bus0.in_ready), 128'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 20-nibble word, both lane orders
        for (int i = 0; i < 20; i++) push(4'(i), 1'b0);
        chk("t1_valid", 128'(bus0.out_valid), 128'd1);
        chk("t1_word_o0", bus0.out, W1_O0);
        chk("t1_count", 128'(bus0.out_count), 128'd20);
        chk("t2_word_o1", bus1.out, W1_O1);
        chk("t2_count", 128'(bus1.out_count), 128'd20);
        @(negedge clk);
        chk("t1_popped", 128'(bus0.out_valid), 128'd0);

        // Early close with in_last, then a fresh word starting at lane 0
        push(4'hA, 1'b0);
        push(4'hB, 1'b0);
        push(4'hC, 1'b1);
        chk("t3_word_o0", bus0.out, 128'hCBA);
        chk("t3_count", 128'(bus0.out_count), 128'd3);
        chk("t3_word_o1", bus1.out, 128'hABC00000000000000000);
        push(4'h5, 1'b1);
        chk("t3_next_o0", bus0.out, 128'h5);
        chk("t3_next_count", 128'(bus0.out_count), 128'd1);
        chk("t3_next_o1", bus1.out, 128'h50000000000000000000);
        @(negedge clk);
        chk("t3_popped", 128'(bus0.out_valid), 128'd0);

        // Backpressure: second word parks in FULL while the first is held
        set_ready(1'b0);
        for (int i = 0; i < 40; i++) push(4'(i), 1'b0);
        chk("t4_full_in_ready", 128'(bus0.in_ready), 128'd0);
        chk("t4_held_valid", 128'(bus0.out_valid), 128'd1);
        chk("t4_held_word", bus0.out, W1_O0);
        repeat (3) @(negedge clk);
        chk("t4_stable_word", bus0.out, W1_O0);
        chk("t4_stable_count", 128'(bus0.out_count), 128'd20);
        set_ready(1'b1);
        @(negedge clk);
        chk("t4_word2", bus0.out, W2_O0);
        chk("t4_word2_valid", 128'(bus0.out_valid), 128'd1);
        chk("t4_refill_ready", 128'(bus0.in_ready), 128'd1);
        @(negedge clk);
        chk("t4_drained", 128'(bus0.out_valid), 128'd0);

        // Steady stream: no stall between words
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            push(4'(i), 1'b0);
            if (i == 19) begin
                chk("t4s_word1", bus0.out, W1_O0);
                chk("t4s_ready", 128'(bus0.in_ready), 128'd1);
            end
        end
        chk("t4s_word2", bus0.out, W2_O0);
        chk("t4s_stalls", 128'(stalls), 128'd0);
        @(negedge clk);

        // Reset in the middle of a word
        for (int i = 0; i < 7; i++) push(4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 128'(bus0.out_valid), 128'd0);
        chk("t5_rst_out", bus0.out, 128'd0);
        chk("t5_rst_ready", 128'(bus0.in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_valid", 128'(bus0.out_valid), 128'd0);
        push(4'h1, 1'b0);
        push(4'h2, 1'b1);
        chk("t5_short", bus0.out, 128'h21);
        chk("t5_short_count", 128'(bus0.out_count), 128'd2);
        for (int i = 0; i < 20; i++) push(4'(i), 1'b0);
        chk("t5_full", bus0.out, W1_O0);
        chk("t5_full_count", 128'(bus0.out_count), 128'd20);
        @(negedge clk);

`ifdef NIBBLES_PACKER_PARITY_EN
        push(4'h7, 1'b0);
        push(4'h3, 1'b0);
        push(4'h0, 1'b1);
        chk("t6_word", bus0.out, 128'h037);
        chk("t6_par", 128'(bus0.out_par), 128'h1);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
